// File: rtl/battleship_game.sv
// battleship_game: two-player Battleship referee. Owns both 10x10 boards,
// runs one command per read/data_ready handshake (placement, then shots)
// and returns a 12-bit result word {code[2:0], player, row[3:0], col[3:0]}.
// Optional feature macro: BATTLESHIP_TURN_CHECK_EN (strict alternating turns).
module battleship_game (
  input  logic        ph1,
  input  logic        reset,
  input  logic        read,
  input  logic        player,
  input  logic        direction,
  input  logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [11:0] data_out,
  output logic        data_ready
);

  localparam int unsigned CELLS = 100;
  localparam int unsigned SHIPS = 5;
  localparam int unsigned CW    = 7;

  localparam logic [2:0] CODE_PLACED  = 3'd1;
  localparam logic [2:0] CODE_REJECT  = 3'd2;
  localparam logic [2:0] CODE_MISS    = 3'd3;
  localparam logic [2:0] CODE_HIT     = 3'd4;
  localparam logic [2:0] CODE_SUNK    = 3'd5;
  localparam logic [2:0] CODE_WIN     = 3'd6;
  localparam logic [2:0] CODE_ILLEGAL = 3'd7;

  localparam logic [3:0] MAX_COORD  = 4'd9;
  localparam logic [2:0] FLEET_DONE = 3'd5;

  typedef enum logic [1:0] {HS_IDLE, HS_EVAL, HS_RESP} hs_e;
  typedef enum logic [1:0] {PH_PLACE, PH_FIRE, PH_OVER} phase_e;

  // Fixed fleet: ship id -> length (id 0 / out of range -> 0)
  function automatic logic [2:0] ship_len(input logic [2:0] id);
    logic [2:0] len;
    case (id)
      3'd1:       len = 3'd5;
      3'd2:       len = 3'd4;
      3'd3, 3'd4: len = 3'd3;
      3'd5:       len = 3'd2;
      default:    len = 3'd0;
    endcase
    return len;
  endfunction

  hs_e    hs_q, hs_d;
  phase_e phase_q;

  logic        cap_player_q, cap_dir_q;
  logic [3:0]  cap_row_q, cap_col_q;
  logic [11:0] data_out_q, data_out_d;
  logic        data_ready_q, data_ready_d;

  // Per-player board state, flattened cell index = row*10 + col
  logic [1:0][CELLS-1:0][2:0] ship_q;
  logic [1:0][CELLS-1:0]      shot_q;
  logic [1:0][SHIPS-1:0][2:0] hits_q;
  logic [1:0][2:0]            idx_q;
  logic [1:0][2:0]            sunk_q;
`ifdef BATTLESHIP_TURN_CHECK_EN
  logic                       turn_q;
`endif

  logic                      other_c;
  logic [2:0]                code_c;
  logic [2:0]                place_id_c, place_len_c;
  logic                      oob_c, overlap_c, place_ok_c;
  logic [4:0]                rk_c, ck_c;
  logic [SHIPS-1:0][CW-1:0]  place_cell_c;
  logic                      fire_in_c, turn_ok_c, shot_ok_c, hit_c, sunk_c, win_c;
  logic [CW-1:0]             fire_cell_c;
  logic [2:0]                fire_sid_c, fire_slot_c, fire_cnt_c;

  // Command evaluation on the captured operands: result code and commit strobes
  always_comb begin
    code_c       = CODE_ILLEGAL;
    place_ok_c   = 1'b0;
    shot_ok_c    = 1'b0;
    hit_c        = 1'b0;
    sunk_c       = 1'b0;
    win_c        = 1'b0;
    oob_c        = 1'b0;
    overlap_c    = 1'b0;
    rk_c         = 5'd0;
    ck_c         = 5'd0;
    place_cell_c = '0;
    other_c      = ~cap_player_q;
    place_id_c   = idx_q[cap_player_q] + 3'd1;
    place_len_c  = ship_len(place_id_c);

    for (int k = 0; k < int'(SHIPS); k++) begin
      rk_c = 5'(cap_row_q) + (cap_dir_q ? 5'(k) : 5'd0);
      ck_c = 5'(cap_col_q) + (cap_dir_q ? 5'd0 : 5'(k));
      place_cell_c[k] = CW'(rk_c) * 7'd10 + CW'(ck_c);
      if (3'(k) < place_len_c) begin
        if ((rk_c > 5'd9) || (ck_c > 5'd9)) begin
          oob_c = 1'b1;
        end else if (ship_q[cap_player_q][place_cell_c[k]] != 3'd0) begin
          overlap_c = 1'b1;
        end
      end
    end

    fire_in_c   = (cap_row_q <= MAX_COORD) && (cap_col_q <= MAX_COORD);
    fire_cell_c = fire_in_c ? (CW'(cap_row_q) * 7'd10 + CW'(cap_col_q)) : '0;
    fire_sid_c  = ship_q[other_c][fire_cell_c];
    fire_slot_c = (fire_sid_c == 3'd0) ? 3'd0 : (fire_sid_c - 3'd1);
    fire_cnt_c  = hits_q[other_c][fire_slot_c] + 3'd1;
`ifdef BATTLESHIP_TURN_CHECK_EN
    turn_ok_c   = (turn_q == cap_player_q);
`else
    turn_ok_c   = 1'b1;
`endif

    case (phase_q)
      PH_PLACE: begin
        if (idx_q[cap_player_q] == FLEET_DONE) begin
          code_c = CODE_ILLEGAL;
        end else if (oob_c || overlap_c) begin
          code_c = CODE_REJECT;
        end else begin
          code_c     = CODE_PLACED;
          place_ok_c = 1'b1;
        end
      end
      PH_FIRE: begin
        if (!fire_in_c || shot_q[other_c][fire_cell_c] || !turn_ok_c) begin
          code_c = CODE_ILLEGAL;
        end else begin
          shot_ok_c = 1'b1;
          if (fire_sid_c == 3'd0) begin
            code_c = CODE_MISS;
          end else begin
            hit_c = 1'b1;
            if (fire_cnt_c == ship_len(fire_sid_c)) begin
              sunk_c = 1'b1;
              if (sunk_q[other_c] == 3'd4) begin
                win_c  = 1'b1;
                code_c = CODE_WIN;
              end else begin
                code_c = CODE_SUNK;
              end
            end else begin
              code_c = CODE_HIT;
            end
          end
        end
      end
      default: code_c = CODE_ILLEGAL;
    endcase
  end

  // Handshake next-state and registered response
  always_comb begin
    hs_d         = hs_q;
    data_out_d   = data_out_q;
    data_ready_d = 1'b0;
    case (hs_q)
      HS_IDLE: if (read) hs_d = HS_EVAL;
      HS_EVAL: begin
        hs_d         = HS_RESP;
        data_out_d   = {code_c, cap_player_q, cap_row_q, cap_col_q};
        data_ready_d = 1'b1;
      end
      HS_RESP: hs_d = HS_IDLE;
      default: hs_d = HS_IDLE;
    endcase
  end

  // Handshake state, operand capture and output registers
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      hs_q         <= HS_IDLE;
      data_out_q   <= 12'h000;
      data_ready_q <= 1'b1;
      cap_player_q <= 1'b0;
      cap_dir_q    <= 1'b0;
      cap_row_q    <= 4'd0;
      cap_col_q    <= 4'd0;
    end else begin
      hs_q         <= hs_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      if ((hs_q == HS_IDLE) && read) begin
        cap_player_q <= player;
        cap_dir_q    <= direction;
        cap_row_q    <= row;
        cap_col_q    <= col;
      end
    end
  end

  // Game state update, committed only in the EVAL cycle
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      phase_q <= PH_PLACE;
      ship_q  <= '0;
      shot_q  <= '0;
      hits_q  <= '0;
      idx_q   <= '0;
      sunk_q  <= '0;
`ifdef BATTLESHIP_TURN_CHECK_EN
      turn_q  <= 1'b0;
`endif
    end else if (hs_q == HS_EVAL) begin
      if (place_ok_c) begin
        for (int k = 0; k < int'(SHIPS); k++) begin
          if (3'(k) < place_len_c) begin
            ship_q[cap_player_q][place_cell_c[k]] <= place_id_c;
          end
        end
        idx_q[cap_player_q] <= place_id_c;
        if ((place_id_c == FLEET_DONE) && (idx_q[other_c] == FLEET_DONE)) begin
          phase_q <= PH_FIRE;
        end
      end
      if (shot_ok_c) begin
        shot_q[other_c][fire_cell_c] <= 1'b1;
        if (hit_c)  hits_q[other_c][fire_slot_c] <= fire_cnt_c;
        if (sunk_c) sunk_q[other_c] <= sunk_q[other_c] + 3'd1;
        if (win_c)  phase_q <= PH_OVER;
`ifdef BATTLESHIP_TURN_CHECK_EN
        turn_q <= ~turn_q;
`endif
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_battleship_game.sv
// tb_battleship_game: directed bench for battleship_game with a rule-level
// game model, a per-cycle response monitor and hand-computed literal pins.
module tb_battleship_game;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        read;
  logic        player;
  logic        direction;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [11:0] data_out;
  logic        data_ready;

  int total = 0;
  int bad   = 0;

  battleship_game dut (
    .ph1        (ph1),
    .reset      (reset),
    .read       (read),
    .player     (player),
    .direction  (direction),
    .row        (row),
    .col        (col),
    .data_out   (data_out),
    .data_ready (data_ready)
  );

  always #5 ph1 = ~ph1;

  // ---------------- game model (board coordinates, rule level) ----------
  int m_ship [2][10][10];
  bit m_shot [2][10][10];
  int m_hits [2][6];
  int m_idx  [2];
  int m_sunk [2];
  int m_phase;   // 0 placing, 1 firing, 2 over
  int m_turn;
  int len_tab [6] = '{0, 5, 4, 3, 3, 2};

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++) begin
          m_ship[p][r][c] = 0;
          m_shot[p][r][c] = 1'b0;
        end
      for (int s = 0; s < 6; s++) m_hits[p][s] = 0;
      m_idx[p]  = 0;
      m_sunk[p] = 0;
    end
    m_phase = 0;
    m_turn  = 0;
  endtask

  task automatic model_cmd(input int p, input int d, input int r, input int c,
                           output logic [11:0] w);
    int code;
    int ok;
    int len;
    int rr;
    int cc;
    int t;
    int sid;
    code = 7;
    if (m_phase == 0) begin
      if (m_idx[p] == 5) begin
        code = 7;
      end else begin
        len = len_tab[m_idx[p] + 1];
        ok  = 1;
        for (int k = 0; k < len; k++) begin
          rr = r + (d != 0 ? k : 0);
          cc = c + (d != 0 ? 0 : k);
          if (rr > 9 || cc > 9) ok = 0;
          else if (m_ship[p][rr][cc] != 0) ok = 0;
        end
        if (ok != 0) begin
          for (int k = 0; k < len; k++) begin
            rr = r + (d != 0 ? k : 0);
            cc = c + (d != 0 ? 0 : k);
            m_ship[p][rr][cc] = m_idx[p] + 1;
          end
          m_idx[p]++;
          code = 1;
          if (m_idx[0] == 5 && m_idx[1] == 5) m_phase = 1;
        end else begin
          code = 2;
        end
      end
    end else if (m_phase == 1) begin
      t = 1 - p;
      if (r > 9 || c > 9) code = 7;
      else if (m_shot[t][r][c]) code = 7;
`ifdef BATTLESHIP_TURN_CHECK_EN
      else if (m_turn != p) code = 7;
`endif
      else begin
        m_shot[t][r][c] = 1'b1;
        m_turn = 1 - m_turn;
        sid = m_ship[t][r][c];
        if (sid == 0) begin
          code = 3;
        end else begin
          m_hits[t][sid]++;
          if (m_hits[t][sid] == len_tab[sid]) begin
            m_sunk[t]++;
            if (m_sunk[t] == 5) begin
              code    = 6;
              m_phase = 2;
            end else begin
              code = 5;
            end
          end else begin
            code = 4;
          end
        end
      end
    end
    w = {3'(code), 1'(p), 4'(r), 4'(c)};
  endtask

  // ---------------- checking ----------------
  logic [11:0] exp_q [$];
  logic [11:0] last_out = 12'h000;
  bit          prev_rdy = 1'b0;

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, want, $time);
    end
  endtask

  // Per-cycle monitor: reset values, one-cycle strobe, response vs model, hold
  always @(negedge ph1) begin
    if (reset) begin
      chk("reset_data_out", data_out, 12'h000);
      chk("reset_data_ready", 12'(data_ready), 12'h001);
      last_out = 12'h000;
      prev_rdy = 1'b0;
    end else if (data_ready) begin
      chk("ready_single_cycle", 12'(prev_rdy), 12'h000);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_response: got=%h expected=none", data_out);
      end else begin
        chk("response", data_out, exp_q.pop_front());
      end
      last_out = data_out;
      prev_rdy = 1'b1;
    end else begin
      chk("data_out_hold", data_out, last_out);
      prev_rdy = 1'b0;
    end
  end

  // One command: read high for one capture edge, operands scrambled afterwards
  task automatic issue(input int p, input int d, input int r, input int c, input int lit);
    logic [11:0] e;
    int          lat;
    bit          got;
    @(posedge ph1); #2;
    player = 1'(p); direction = 1'(d); row = 4'(r); col = 4'(c); read = 1'b1;
    model_cmd(p, d, r, c, e);
    exp_q.push_back(e);
    @(posedge ph1); #2;
    read = 1'b0;
    player = 1'($urandom); direction = 1'($urandom);
    row = 4'($urandom); col = 4'($urandom);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 6) begin
      @(negedge ph1);
      lat++;
      if (data_ready) got = 1'b1;
    end
    chk("ready_latency", 12'(lat), 12'd2);
    if (lit >= 0) chk("literal", data_out, 12'(lit));
    @(posedge ph1);
  endtask

  // read held high: a second command is taken once back in IDLE
  task automatic issue_held(input int p, input int d, input int r, input int c,
                            input int lit1, input int lit2);
    logic [11:0] e;
    logic [11:0] seen [2];
    int          n;
    int          cyc;
    @(posedge ph1); #2;
    player = 1'(p); direction = 1'(d); row = 4'(r); col = 4'(c); read = 1'b1;
    model_cmd(p, d, r, c, e); exp_q.push_back(e);
    model_cmd(p, d, r, c, e); exp_q.push_back(e);
    n = 0;
    cyc = 0;
    seen[0] = 12'h000;
    seen[1] = 12'h000;
    while (n < 2 && cyc < 14) begin
      @(negedge ph1);
      cyc++;
      if (data_ready) begin
        seen[n] = data_out;
        n++;
      end
    end
    #1 read = 1'b0;
    chk("held_read_count", 12'(n), 12'd2);
    chk("held_literal_1", seen[0], 12'(lit1));
    chk("held_literal_2", seen[1], 12'(lit2));
    @(posedge ph1);
  endtask

  int tr [17] = '{9, 9, 9, 9, 9, 0, 1, 2, 3, 5, 6, 7, 0, 0, 0, 8, 8};
  int tc [17] = '{5, 6, 7, 8, 9, 9, 9, 9, 9, 0, 0, 0, 0, 1, 2, 8, 9};

  initial begin
    int lit;
    model_reset();
    reset = 1'b1; read = 1'b0; player = 1'b0; direction = 1'b0;
    row = 4'd0; col = 4'd0;
    repeat (2) @(posedge ph1);
    @(negedge ph1); #2 reset = 1'b0;
    @(negedge ph1);
    chk("ready_after_release", 12'(data_ready), 12'h000);

    // P0 fleet, with an overlap rejection and a held-read pair
    issue(0, 0, 0, 0, 'h200);
    issue(0, 1, 0, 3, 'h403);
    issue(0, 0, 1, 0, 'h210);
    issue_held(0, 0, 2, 0, 'h220, 'h420);
    issue(0, 0, 3, 0, 'h230);
    issue(0, 0, 4, 0, 'h240);
    issue(0, 0, 7, 7, 'hE77);

    // P1 fleet with out-of-range rejections
    issue(1, 0, 9, 6, 'h596);
    issue(1, 0, 12, 0, 'h5C0);
    issue(1, 0, 9, 5, 'h395);
    issue(1, 1, 0, 9, 'h309);
    issue(1, 1, 5, 0, 'h350);
    issue(1, 0, 0, 0, 'h300);
    issue(1, 0, 8, 8, 'h388);

    // Opening shots: P1 out of turn (legal only without turn checking)
    issue(1, 0, 9, 9, -1);
    issue(0, 0, 5, 5, 'h655);
    issue(1, 0, 4, 0, 'h940);
    issue(0, 0, 6, 6, 'h666);
    issue(1, 0, 4, 1, 'hB41);
    issue(0, 0, 7, 7, 'h677);
    issue(1, 0, 4, 1, 'hF41);
    issue(1, 0, 9, 8, 'h798);
    issue(0, 0, 10, 0, 'hEA0);

    // P0 sinks the whole P1 fleet, P1 misses in between
    for (int i = 0; i < 17; i++) begin
      lit = (i == 0) ? 'h895 : (i == 4) ? 'hA99 : (i == 16) ? 'hC89 : -1;
      issue(0, 0, tr[i], tc[i], lit);
      if (i < 16) issue(1, 0, (i < 10) ? 8 : 9, (i < 10) ? i : i - 10, -1);
    end

    // Game over: everything illegal
    issue(1, 0, 5, 5, 'hF55);
    issue(0, 1, 0, 0, 'hE00);

    // Reset during EVAL aborts the command and clears the game
    @(posedge ph1); #2;
    player = 1'b0; direction = 1'b0; row = 4'd3; col = 4'd3; read = 1'b1;
    @(posedge ph1); #2;
    reset = 1'b1; read = 1'b0;
    model_reset();
    repeat (2) @(posedge ph1);
    @(negedge ph1); #2 reset = 1'b0;
    @(negedge ph1);
    chk("ready_after_abort", 12'(data_ready), 12'h000);
    issue(0, 0, 0, 0, 'h200);
    issue(1, 0, 0, 0, 'h300);

    repeat (3) @(negedge ph1);
    chk("pending_responses", 12'(exp_q.size()), 12'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
